// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// aes_pkg : shared AES GF(2^8) helpers, state layout constants, FSM states
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;
    localparam int STATE_W  = COL_W * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_09(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul_0b(input logic [7:0] x);
        logic [7:0] x2, x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul_0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul_0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mix_col_word.sv
//------------------------------------------------------------------------------
// inv_mix_col_word : combinational InvMixColumns transform of one 32-bit column
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inv_mix_col_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    output logic [COL_W-1:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_b0, w_b1, w_b2, w_b3;

    // Row 0 is the most significant byte of the column.
    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_b0 = gf_mul_0e(w_a0) ^ gf_mul_0b(w_a1) ^ gf_mul_0d(w_a2) ^ gf_mul_09(w_a3);
    assign w_b1 = gf_mul_09(w_a0) ^ gf_mul_0e(w_a1) ^ gf_mul_0b(w_a2) ^ gf_mul_0d(w_a3);
    assign w_b2 = gf_mul_0d(w_a0) ^ gf_mul_09(w_a1) ^ gf_mul_0e(w_a2) ^ gf_mul_0b(w_a3);
    assign w_b3 = gf_mul_0b(w_a0) ^ gf_mul_0d(w_a1) ^ gf_mul_09(w_a2) ^ gf_mul_0e(w_a3);

    assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
//------------------------------------------------------------------------------
// inv_mix_columns_seq : iterative InvMixColumns, one column per clock, valid/ready
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [STATE_W-1:0]   state_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [STATE_W-1:0]   state_out
);

    fsm_state_e           state_q, state_d;
    logic [1:0]           col_q, col_d;
    logic [STATE_W-1:0]   work_q, work_d;
    logic                 out_valid_q, out_valid_d;

    logic [COL_W-1:0]     w_col_in;
    logic [COL_W-1:0]     w_col_out;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = out_valid_q;
    assign state_out = work_q;

    always_comb begin
        w_col_in = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == c[1:0]) begin
                w_col_in = work_q[STATE_W-1-COL_W*c -: COL_W];
            end
        end
    end

    inv_mix_col_word u_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        work_d      = work_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = state_in;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (col_q == c[1:0]) begin
                        work_d[STATE_W-1-COL_W*c -: COL_W] = w_col_out;
                    end
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // Result leaves on the handshake; a waiting state may load on the same edge.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        work_d  = state_in;
                        col_d   = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                col_d       = 2'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
//------------------------------------------------------------------------------
// tb_inv_mix_columns_seq : directed bench with a matrix-level GF(2^8) model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [127:0] exp_q[$];
    int           acc_t[$];
    int           hs_t[$];

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mat_mul(input logic [127:0] s, input logic [31:0] row0);
        logic [127:0] r = '0;
        logic [7:0]   m[4];
        logic [7:0]   a[4];
        logic [7:0]   acc;
        for (int k = 0; k < 4; k++) m[k] = row0[31-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                // Circulant matrix: row i is row 0 rotated right by i.
                for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - i + 4) % 4], a[j]);
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        return mat_mul(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        return mat_mul(s, 32'h02030101);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: checks state_out whenever out_valid, tracks accepts and handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 128'd1, 128'd0);
                end else begin
                    chk("scoreboard", state_out, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_t.push_back(cyc + 1);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(inv_model(state_in));
                acc_t.push_back(cyc + 1);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic send(input logic [127:0] x, input bit keep);
        int n = 0;
        in_valid = 1'b1;
        state_in = x;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) chk("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_hs(output logic [127:0] res);
        int n = 0;
        res = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_ready) && n < 60);
        if (!(out_valid && out_ready)) chk("out_timeout", 128'd0, 128'd1);
        res = state_out;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 128'd0, 128'd1);
    endtask

    logic [127:0] res, held, x;

    initial begin
        // Pin the model to known FIPS-197 columns.
        chk("model_inv_fips", inv_model(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6),
            128'hdb135345_f20a225c_01010101_d4d4d4d5);
        chk("model_fwd_fips", fwd_model(128'hdb135345_f20a225c_01010101_d4d4d4d5),
            128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6);

        #12;
        chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_state_out", state_out, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS vector with exact latency.
        out_ready = 1'b1;
        send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("latency_n%0d", i), {127'd0, out_valid}, (i == 4) ? 128'd1 : 128'd0);
        end
        chk("fips_out", state_out, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
        @(posedge clk);
        #1;
        drain();

        // Identity-ish patterns.
        send(128'h0, 1'b0);
        wait_hs(res);
        chk("all_zero", res, 128'h0);
        send({16{8'h01}}, 1'b0);
        wait_hs(res);
        chk("all_01", res, {16{8'h01}});

        // Round-trip through forward MixColumns.
        for (int t = 0; t < 200; t++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(fwd_model(x), 1'b0);
            wait_hs(res);
            if (t < 5 || res !== x) chk("round_trip", res, x);
        end
        drain();

        // Backpressure with a second state waiting.
        out_ready = 1'b0;
        send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0);
        in_valid = 1'b1;
        state_in = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
        end
        held = state_out;
        chk("bp_first_value", held, inv_model(128'h00112233_44556677_8899aabb_ccddeeff));
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            chk("bp_state_out", state_out, held);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", {126'd0, exp_q.size() == 1, 1'b0}, {126'd0, 1'b1, 1'b0});
        drain();

        // Back-to-back with out_ready held high.
        acc_t.delete();
        hs_t.delete();
        send(128'h01234567_89abcdef_fedcba98_76543210, 1'b1);
        send(128'hdeadbeef_cafef00d_13579bdf_2468ace0, 1'b0);
        drain();
        if (acc_t.size() == 2 && hs_t.size() == 2) begin
            chk("b2b_accept_period", acc_t[1] - acc_t[0], 128'd5);
            chk("b2b_accept_on_hs", hs_t[0], acc_t[1]);
            chk("b2b_out_period", hs_t[1] - hs_t[0], 128'd5);
        end else begin
            chk("b2b_counts", acc_t.size() * 16 + hs_t.size(), 128'h22);
        end

        // Reset during column 2.
        send(128'hffffffff_00000000_a5a5a5a5_5a5a5a5a, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_state_out", state_out, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stale", {127'd0, out_valid}, 128'd0);
        end
        @(posedge clk);
        #1;
        send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0);
        wait_hs(res);
        chk("after_rst_fips", res, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
